// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA pixel pipeline
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int H_ACTIVE  = 1024;
    localparam int V_ACTIVE  = 768;
    // Eight equal-width colour bars across the visible line
    localparam int BAR_SHIFT = $clog2(H_ACTIVE / 8);

    localparam rgb12_t BAR_COLOURS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Per-pixel control that travels alongside the framebuffer read
    typedef struct packed {
        logic       active;
        logic       pat;
        logic [2:0] bar;
        logic       first;
        logic       hs;
        logic       vs;
    } pix_stage_t;

    localparam pix_stage_t STAGE_IDLE = '{
        active: 1'b0, pat: 1'b0, bar: 3'd0, first: 1'b0, hs: 1'b1, vs: 1'b1
    };

    function automatic rgb12_t bar_colour(input logic [2:0] bar);
        return BAR_COLOURS[bar];
    endfunction

endpackage

// File: rtl/vga_palette.sv
// rtl/vga_palette.sv - 16-entry 12-bit palette, synchronous write, combinational read
module vga_palette
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       we_i,
    input  logic [3:0] wr_idx_i,
    input  rgb12_t     wr_rgb_i,
    input  logic [3:0] rd_idx_i,
    output rgb12_t     rd_rgb_o
);

    rgb12_t mem_q [16];

    // Entries come out of reset as a grey ramp; writes land on the clock edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (we_i) begin
            mem_q[wr_idx_i] <= wr_rgb_i;
        end
    end

    // A same-cycle write is not forwarded: the reader sees the old entry
    assign rd_rgb_o = mem_q[rd_idx_i];

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - three-stage framebuffer/palette pixel pipeline with test pattern
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int unsigned FB_W        = 256,
    parameter int unsigned FB_H        = 192,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [10:0] hc_visible,
    input  logic [10:0] vc_visible,
    input  logic        pattern_en,
    output logic        fb_rd_en,
    output logic [15:0] fb_addr,
    input  logic [3:0]  fb_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [11:0] pal_rgb,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    logic        active;
    logic [10:0] col;
    logic [10:0] row;
    logic        in_fb;
    logic        rd_en_d;
    logic [15:0] addr_d;
    pix_stage_t  s1_d;
    pix_stage_t  s1_q;
    pix_stage_t  s2_q;
    logic        fb_rd_en_q;
    logic [15:0] fb_addr_q;
    rgb12_t      pal_rd;
    rgb12_t      colour_d;
    rgb12_t      rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        frame_start_q;

    assign active = (hc_visible != 11'd0) && (vc_visible != 11'd0);
    assign col    = (hc_visible - 11'd1) >> SCALE_SHIFT;
    assign row    = (vc_visible - 11'd1) >> SCALE_SHIFT;
    assign in_fb  = (32'(row) < FB_H) && (32'(col) < FB_W);
    assign addr_d = 16'(row) * 16'(FB_W) + 16'(col);

    // Stage-1 inputs: read request and the control that rides with this pixel
    always_comb begin
        rd_en_d     = active && !pattern_en && in_fb;
        s1_d        = STAGE_IDLE;
        s1_d.active = active;
        s1_d.pat    = pattern_en;
        s1_d.bar    = 3'((hc_visible - 11'd1) >> BAR_SHIFT);
        s1_d.first  = (hc_visible == 11'd1) && (vc_visible == 11'd1);
        s1_d.hs     = hs_in;
        s1_d.vs     = vs_in;
    end

    // Stage 1: issue the framebuffer read; address holds while no read is issued
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= STAGE_IDLE;
            fb_rd_en_q <= 1'b0;
            fb_addr_q  <= 16'd0;
        end else begin
            s1_q       <= s1_d;
            fb_rd_en_q <= rd_en_d;
            if (rd_en_d) begin
                fb_addr_q <= addr_d;
            end
        end
    end

    // Stage 2: wait out the RAM read latency so control lines up with fb_data
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= STAGE_IDLE;
        end else begin
            s2_q <= s1_q;
        end
    end

    vga_palette u_palette (
        .clk_i    (clk_vga),
        .rst_n_i  (rst_n),
        .we_i     (pal_we),
        .wr_idx_i (pal_idx),
        .wr_rgb_i (pal_rgb),
        .rd_idx_i (fb_data),
        .rd_rgb_o (pal_rd)
    );

    // Colour select: blanking is black, pattern mode overrides the palette
    always_comb begin
        colour_d = 12'h000;
        if (s2_q.active) begin
            colour_d = s2_q.pat ? bar_colour(s2_q.bar) : pal_rd;
        end
    end

    // Stage 3: register colour, syncs and frame marker together
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= 12'h000;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= colour_d;
            hs_q          <= s2_q.hs;
            vs_q          <= s2_q.vs;
            frame_start_q <= s2_q.first;
        end
    end

    assign fb_rd_en    = fb_rd_en_q;
    assign fb_addr     = fb_addr_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - self-checking bench for vga_pixel_pipe
module tb_vga_pixel_pipe;
    import vga_pkg::*;

    logic        clk_vga;
    logic        rst_n;
    logic        hs_in;
    logic        vs_in;
    logic [10:0] hc_visible;
    logic [10:0] vc_visible;
    logic        pattern_en;
    logic        fb_rd_en;
    logic [15:0] fb_addr;
    logic [3:0]  fb_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_rgb;
    logic        hs;
    logic        vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    vga_pixel_pipe dut (
        .clk_vga     (clk_vga),
        .rst_n       (rst_n),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .hc_visible  (hc_visible),
        .vc_visible  (vc_visible),
        .pattern_en  (pattern_en),
        .fb_rd_en    (fb_rd_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_rgb     (pal_rgb),
        .hs          (hs),
        .vs          (vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    // Framebuffer contents, shared by the RAM model and the reference
    logic [3:0] mem [65536];

    always @(posedge clk_vga) begin
        if (fb_rd_en) fb_data <= mem[fb_addr];
    end

    typedef struct {
        int hc;
        int vc;
        bit pat;
        bit hs;
        bit vs;
    } px_t;

    int          checks   = 0;
    int          failures = 0;
    px_t         hist [1:3];
    px_t         cur;
    logic [11:0] pal_m [16];
    int          addr_hold;
    int          fs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int spec_addr(input int hc, input int vc);
        return ((vc - 1) / 4) * 256 + (hc - 1) / 4;
    endfunction

    function automatic logic [11:0] bar_exp(input int hc);
        case ((hc - 1) / 128)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic reset_model();
        px_t idle;
        logic [3:0] v;
        idle = '{0, 0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            pal_m[i] = {v, v, v};
        end
        hist[1] = idle;
        hist[2] = idle;
        hist[3] = idle;
        addr_hold = 0;
    endtask

    task automatic drive(input int hc, input int vc, input bit pat, input bit h, input bit v);
        hc_visible = 11'(hc);
        vc_visible = 11'(vc);
        pattern_en = pat;
        hs_in      = h;
        vs_in      = v;
        cur        = '{hc, vc, pat, h, v};
    endtask

    // Compare every output against the reference for the current cycle
    task automatic check_cycle();
        px_t a;
        px_t t;
        bit rd;
        logic [11:0] exp_rgb;
        a = hist[1];
        t = hist[3];
        rd = (a.hc != 0) && (a.vc != 0) && !a.pat;
        if (rd) addr_hold = spec_addr(a.hc, a.vc);
        if (t.hc == 0 || t.vc == 0) exp_rgb = 12'h000;
        else if (t.pat)             exp_rgb = bar_exp(t.hc);
        else                        exp_rgb = pal_m[mem[spec_addr(t.hc, t.vc)]];
        chk("fb_rd_en", 32'(fb_rd_en), 32'(rd));
        chk("fb_addr", 32'(fb_addr), 32'(addr_hold));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        chk("hs", 32'(hs), 32'(t.hs));
        chk("vs", 32'(vs), 32'(t.vs));
        chk("frame_start", 32'(frame_start), 32'((t.hc == 1) && (t.vc == 1)));
    endtask

    task automatic step();
        logic        wv;
        logic [3:0]  wi;
        logic [11:0] wr;
        wv = pal_we;
        wi = pal_idx;
        wr = pal_rgb;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = cur;
        @(posedge clk_vga);
        #1;
        check_cycle();
        if (frame_start) fs_count++;
        if (wv) pal_m[wi] = wr;
    endtask

    task automatic do_reset();
        pal_we = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        reset_model();
        @(posedge clk_vga);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int a;
        for (int i = 0; i < 65536; i++) mem[i] = 4'($urandom);
        fb_data  = 4'd0;
        rst_n    = 1'b0;
        pal_we   = 1'b0;
        pal_idx  = 4'd0;
        pal_rgb  = 12'd0;
        fs_count = 0;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        @(posedge clk_vga);
        #1;
        do_reset();

        // Random pixels, pattern switching and palette writes
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4 == 0) ? 0 : int'($urandom_range(1, H_ACTIVE - 1)),
                  ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, V_ACTIVE - 1)),
                  ($urandom % 3 == 0), 1'($urandom), 1'($urandom));
            pal_we  = ($urandom % 6 == 0);
            pal_idx = 4'($urandom);
            pal_rgb = 12'($urandom);
            step();
        end
        pal_we = 1'b0;

        // Reset asserted mid-line with syncs low in the pipe
        for (int n = 0; n < 5; n++) begin
            drive(100 + n, 50, 1'b0, 1'b0, 1'b0);
            step();
        end
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drive(200 + n, 60, 1'b0, 1'b0, 1'b1);
            step();
        end

        // Address map corners
        drive(5, 9, 1'b0, 1'b1, 1'b1);
        step();
        chk("addr_5_9", 32'(fb_addr), 32'h0201);
        chk("rd_en_5_9", 32'(fb_rd_en), 32'd1);
        drive(1023, 767, 1'b0, 1'b1, 1'b1);
        step();
        chk("addr_last", 32'(fb_addr), 32'hBFFF);

        // Latency with default palette and a sync edge
        a = spec_addr(40, 20);
        mem[a] = 4'h7;
        drive(40, 20, 1'b0, 1'b0, 1'b0);
        step();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("latency_rgb", 32'({vga_r, vga_g, vga_b}), 32'h777);
        chk("latency_hs", 32'(hs), 32'd0);
        step();
        chk("latency_hs_rise", 32'(hs), 32'd1);

        // Pattern mode
        drive(129, 10, 1'b1, 1'b1, 1'b1);
        step();
        chk("pat_rd_en", 32'(fb_rd_en), 32'd0);
        drive(0, 10, 1'b1, 1'b1, 1'b1);
        step();
        chk("pat_rd_en2", 32'(fb_rd_en), 32'd0);
        step();
        chk("pat_rgb_ff0", 32'({vga_r, vga_g, vga_b}), 32'hFF0);
        step();
        chk("pat_rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'h000);
        chk("pat_rd_en3", 32'(fb_rd_en), 32'd0);

        // Palette write colliding with the lookup of index 3
        mem[spec_addr(60, 30)] = 4'h3;
        mem[spec_addr(64, 30)] = 4'h3;
        drive(60, 30, 1'b0, 1'b1, 1'b1);
        step();
        drive(64, 30, 1'b0, 1'b1, 1'b1);
        step();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        pal_we  = 1'b1;
        pal_idx = 4'd3;
        pal_rgb = 12'hABC;
        step();
        pal_we = 1'b0;
        chk("collide_old", 32'({vga_r, vga_g, vga_b}), 32'h333);
        step();
        chk("collide_new", 32'({vga_r, vga_g, vga_b}), 32'hABC);

        // Two small frames: one frame_start each
        for (int f = 0; f < 2; f++) begin
            fs_count = 0;
            for (int l = 0; l < 8; l++) begin
                for (int c = 0; c < 24; c++) begin
                    drive((c < 16) ? c + 1 : 0, (l < 6) ? l + 1 : 0,
                          ($urandom % 2 == 0), (c < 20), (l < 7));
                    step();
                end
            end
            chk("frame_start_count", 32'(fs_count), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
